// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: widths, NOP,
// stall polarity and the FIFO entry payload.
package if_fetch_pkg;

  localparam int unsigned ADDR_WIDTH       = 32;
  localparam int unsigned DATA_WIDTH       = 32;
  localparam int unsigned STALL_WIDTH      = 6;
  localparam int unsigned STALL_PC         = 0;
  localparam int unsigned STALL_IFID       = 1;
  localparam int unsigned FETCH_FIFO_DEPTH = 2;

  localparam logic [ADDR_WIDTH-1:0] RESET_ADDR_DEFAULT = 32'h0000_0000;
  localparam logic [DATA_WIDTH-1:0] NOP                = 32'h0000_0013;
  localparam logic                  STOP               = 1'b1;
  localparam logic                  NOSTOP             = 1'b0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] inst;
  } fetch_entry_t;

  // Circular pointer increment for queues of arbitrary depth.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return ((ptr + 32'd1) >= depth) ? 32'd0 : (ptr + 32'd1);
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Request/grant/response instruction bus between the fetch unit and memory.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/if_fetch_fetch_fifo.sv
// Synchronous FIFO of {addr, inst} entries with push, pop and clear.
module if_fetch_fetch_fifo
  import if_fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = FETCH_FIFO_DEPTH,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  fetch_entry_t     i_data,
  output fetch_entry_t     o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  assign w_pop   = i_pop && (r_count != '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= PTR_W'(ptr_next(32'(r_wr_ptr), DEPTH));
      end
      if (w_pop) r_rd_ptr <= PTR_W'(ptr_next(32'(r_rd_ptr), DEPTH));
      unique case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The issue credit guarantees a free slot for every response that lands.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(i_push && !i_clear && (r_count == CNT_W'(DEPTH))));

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, issues word fetches, buffers
// responses and presents one instruction per cycle to IF/ID.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = RESET_ADDR_DEFAULT,
  parameter int unsigned           FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [STALL_WIDTH-1:0] stall_i,
  input  logic                   jump_flag_i,
  input  logic [ADDR_WIDTH-1:0]  jump_addr_i,
  input  logic                   int_flag_i,
  input  logic [ADDR_WIDTH-1:0]  int_addr_i,
  if_fetch_if.master             ibus,
  output logic [ADDR_WIDTH-1:0]  inst_addr_o,
  output logic [DATA_WIDTH-1:0]  inst_o,
  output logic                   fetch_empty_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [CNT_W-1:0]      r_outstanding;
  logic [CNT_W-1:0]      r_drop_cnt;
  logic                  r_run;
  logic                  r_req_hold;
  logic [ADDR_WIDTH-1:0] r_aq [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_aq_wr;
  logic [PTR_W-1:0]      r_aq_rd;

  logic                  w_redirect;
  logic [ADDR_WIDTH-1:0] w_target;
  logic                  w_credit;
  logic                  w_req;
  logic                  w_gnt;
  logic                  w_rvalid;
  logic                  w_push;
  logic                  w_pop;
  logic [CNT_W-1:0]      w_count;
  logic                  w_empty;
  fetch_entry_t          w_entry;
  fetch_entry_t          w_head;
  logic                  w_unused_stall;

  assign w_unused_stall = ^stall_i[STALL_WIDTH-1:2];

  assign w_redirect = int_flag_i | jump_flag_i;
  assign w_target   = int_flag_i ? int_addr_i : jump_addr_i;
  assign w_credit   = ((CNT_W + 1)'(r_outstanding) + (CNT_W + 1)'(w_count)) < (CNT_W + 1)'(FIFO_DEPTH);

  // A raised request is held until granted; only a redirect withdraws it.
  assign w_req    = r_run && !w_redirect &&
                    (r_req_hold || ((stall_i[STALL_PC] == NOSTOP) && w_credit));
  assign w_gnt    = w_req && ibus.gnt;
  assign w_rvalid = ibus.rvalid && (r_outstanding != '0);
  assign w_push   = w_rvalid && (r_drop_cnt == '0) && !w_redirect;
  assign w_pop    = !w_empty && (stall_i[STALL_IFID] == NOSTOP) && !w_redirect;

  assign ibus.req  = w_req;
  assign ibus.addr = r_pc;

  assign w_entry.addr = r_aq[r_aq_rd];
  assign w_entry.inst = ibus.rdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc       <= RESET_ADDR;
      r_run      <= 1'b0;
      r_req_hold <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_redirect) begin
        r_pc       <= w_target;
        r_req_hold <= 1'b0;
      end else if (w_gnt) begin
        r_pc       <= r_pc + ADDR_WIDTH'(4);
        r_req_hold <= 1'b0;
      end else if (w_req) begin
        r_req_hold <= 1'b1;
      end
    end
  end

  // Responses already in flight at a redirect are counted out and discarded.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      unique case ({w_gnt, w_rvalid})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_redirect)
        r_drop_cnt <= r_outstanding + CNT_W'(w_gnt) - CNT_W'(w_rvalid);
      else if (w_rvalid && (r_drop_cnt != '0))
        r_drop_cnt <= r_drop_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_aq[i] <= '0;
      r_aq_wr <= '0;
      r_aq_rd <= '0;
    end else begin
      if (w_gnt) begin
        r_aq[r_aq_wr] <= r_pc;
        r_aq_wr       <= PTR_W'(ptr_next(32'(r_aq_wr), FIFO_DEPTH));
      end
      if (w_rvalid) r_aq_rd <= PTR_W'(ptr_next(32'(r_aq_rd), FIFO_DEPTH));
    end
  end

  if_fetch_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_redirect),
    .i_data  (w_entry),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  always_comb begin
    inst_o        = NOP;
    inst_addr_o   = '0;
    fetch_empty_o = 1'b1;
    if (!w_empty) begin
      inst_o        = w_head.inst;
      inst_addr_o   = w_head.addr;
      fetch_empty_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Randomised bench for if_fetch: a queue-based reference model plus a
// variable-latency memory slave, with directed redirect and reset scenarios.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam int unsigned           DEPTH    = FETCH_FIFO_DEPTH;
  localparam logic [ADDR_WIDTH-1:0] RST_ADDR = 32'h0000_0000;

  logic                  clk_i;
  logic                  rst_i;
  logic [5:0]            stall_i;
  logic                  jump_flag_i;
  logic [31:0]           jump_addr_i;
  logic                  int_flag_i;
  logic [31:0]           int_addr_i;
  logic [31:0]           inst_addr_o;
  logic [31:0]           inst_o;
  logic                  fetch_empty_o;

  if_fetch_if ibus ();

  if_fetch #(
    .RESET_ADDR (RST_ADDR),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .jump_flag_i   (jump_flag_i),
    .jump_addr_i   (jump_addr_i),
    .int_flag_i    (int_flag_i),
    .int_addr_i    (int_addr_i),
    .ibus          (ibus),
    .inst_addr_o   (inst_addr_o),
    .inst_o        (inst_o),
    .fetch_empty_o (fetch_empty_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct { logic [31:0] addr; bit drop; } flight_t;
  typedef struct { logic [31:0] addr; logic [31:0] inst; } ent_t;
  typedef struct { logic [31:0] addr; int due; } rsp_t;

  // Reference model: PC, fetches in flight, instruction buffer.
  logic [31:0] m_pc;
  bit          m_run;
  bit          m_pending;
  flight_t     m_flight[$];
  ent_t        m_fifo[$];

  // Memory slave state.
  rsp_t        s_q[$];
  int          last_due;
  bit          stale;

  int          cyc;
  int          rel_cyc;
  int          first_req;
  logic [31:0] grant_log[$];
  logic [31:0] pres_log[$];
  int          n_checks;
  int          n_errors;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5EED_0001;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset(input bit mid);
    @(negedge clk_i);
    rst_i       = 1'b1;
    stall_i     = '0;
    jump_flag_i = 1'b0;
    int_flag_i  = 1'b0;
    ibus.gnt    = 1'b0;
    ibus.rvalid = 1'b0;
    #1;
    check_eq("rst_req",       32'(ibus.req),      32'd0);
    check_eq("rst_inst",      inst_o,             NOP);
    check_eq("rst_inst_addr", inst_addr_o,        32'd0);
    check_eq("rst_empty",     32'(fetch_empty_o), 32'd1);
    @(posedge clk_i);
    m_pc      = RST_ADDR;
    m_run     = 1'b0;
    m_pending = 1'b0;
    m_flight.delete();
    m_fifo.delete();
    s_q.delete();
    last_due  = cyc;
    stale     = mid;
    rel_cyc   = 0;
    first_req = -1;
    grant_log.delete();
  endtask

  task automatic step(input logic [5:0] st, input logic jf, input logic [31:0] ja,
                      input logic itf, input logic [31:0] ia,
                      input int unsigned gnt_pct, input int unsigned lat_max);
    logic        redirect;
    logic [31:0] target;
    logic        exp_req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    flight_t     h;
    bit          rv_eff;
    int          due;
    @(negedge clk_i);
    rst_i       = 1'b0;
    stall_i     = st;
    jump_flag_i = jf;
    jump_addr_i = ja;
    int_flag_i  = itf;
    int_addr_i  = ia;
    redirect = jf | itf;
    target   = itf ? ia : ja;
    exp_req  = m_run && !redirect &&
               (m_pending || (!st[0] && ((m_flight.size() + m_fifo.size()) < int'(DEPTH))));
    gnt   = exp_req && ($urandom_range(99) < gnt_pct);
    rv    = 1'b0;
    rdata = '0;
    if (stale) begin
      rv    = 1'b1;
      rdata = 32'hDEAD_BEEF;
      stale = 1'b0;
    end else if (s_q.size() > 0 && s_q[0].due <= cyc) begin
      rv    = 1'b1;
      rdata = mem_word(s_q[0].addr);
      void'(s_q.pop_front());
    end
    ibus.gnt    = gnt;
    ibus.rvalid = rv;
    ibus.rdata  = rdata;
    #1;
    check_eq("req", 32'(ibus.req), 32'(exp_req));
    if (exp_req) check_eq("addr", ibus.addr, m_pc);
    if (m_fifo.size() == 0) begin
      check_eq("empty", 32'(fetch_empty_o), 32'd1);
      check_eq("inst_nop", inst_o, NOP);
      check_eq("inst_addr_zero", inst_addr_o, 32'd0);
    end else begin
      check_eq("empty", 32'(fetch_empty_o), 32'd0);
      check_eq("inst", inst_o, m_fifo[0].inst);
      check_eq("inst_addr", inst_addr_o, m_fifo[0].addr);
    end
    if (ibus.req && first_req < 0) first_req = rel_cyc;
    if (ibus.req && ibus.gnt) grant_log.push_back(ibus.addr);
    if (!fetch_empty_o && !st[1] && !redirect) pres_log.push_back(inst_addr_o);
    @(posedge clk_i);
    if (gnt) begin
      due = cyc + int'($urandom_range(lat_max, 1));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      s_q.push_back('{addr: m_pc, due: due});
    end
    rv_eff = rv && (m_flight.size() > 0);
    if (rv_eff) h = m_flight.pop_front();
    if (redirect) begin
      m_pc = target;
      m_fifo.delete();
      foreach (m_flight[i]) m_flight[i].drop = 1'b1;
      m_pending = 1'b0;
    end else begin
      if (m_fifo.size() > 0 && !st[1]) void'(m_fifo.pop_front());
      if (rv_eff && !h.drop) m_fifo.push_back('{addr: h.addr, inst: rdata});
      if (gnt) begin
        m_flight.push_back('{addr: m_pc, drop: 1'b0});
        m_pc      = m_pc + 32'd4;
        m_pending = 1'b0;
      end else if (exp_req) begin
        m_pending = 1'b1;
      end
    end
    m_run = 1'b1;
    cyc++;
    rel_cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          seen;
    logic [5:0]  st;
    int unsigned r;
    n_checks    = 0;
    n_errors    = 0;
    cyc         = 0;
    rst_i       = 1'b1;
    stall_i     = '0;
    jump_flag_i = 1'b0;
    jump_addr_i = '0;
    int_flag_i  = 1'b0;
    int_addr_i  = '0;
    ibus.gnt    = 1'b0;
    ibus.rvalid = 1'b0;
    ibus.rdata  = '0;

    // Single-cycle memory after reset.
    do_reset(1'b0);
    repeat (16) step(6'b0, 1'b0, 32'd0, 1'b0, 32'd0, 100, 1);
    check_eq("first_req_cyc", 32'(first_req), 32'd1);
    if (grant_log.size() < 4) check_eq("grant_len", 32'(grant_log.size()), 32'd4);
    else begin
      check_eq("grant0", grant_log[0], 32'h0);
      check_eq("grant1", grant_log[1], 32'h4);
      check_eq("grant2", grant_log[2], 32'h8);
      check_eq("grant3", grant_log[3], 32'hC);
    end

    // IF/ID stall fills the buffer, then full stall, then release.
    repeat (4) step(6'b000010, 1'b0, 32'd0, 1'b0, 32'd0, 100, 1);
    repeat (3) step(6'b000011, 1'b0, 32'd0, 1'b0, 32'd0, 100, 1);
    repeat (8) step(6'b000000, 1'b0, 32'd0, 1'b0, 32'd0, 100, 1);

    // Jump with two fetches in flight.
    for (int i = 0; i < 20 && m_flight.size() < 2; i++)
      step(6'b0, 1'b0, 32'd0, 1'b0, 32'd0, 100, 3);
    check_eq("inflight_before_jump", 32'(m_flight.size()), 32'd2);
    pres_log.delete();
    step(6'b0, 1'b1, 32'h100, 1'b0, 32'd0, 100, 3);
    repeat (20) step(6'b0, 1'b0, 32'd0, 1'b0, 32'd0, 100, 3);
    if (pres_log.size() < 2) check_eq("jump_pres_len", 32'(pres_log.size()), 32'd2);
    else begin
      check_eq("jump_first", pres_log[0], 32'h100);
      check_eq("jump_second", pres_log[1], 32'h104);
    end

    // Interrupt wins over a simultaneous jump.
    pres_log.delete();
    step(6'b0, 1'b1, 32'h200, 1'b1, 32'h80, 100, 2);
    repeat (16) step(6'b0, 1'b0, 32'd0, 1'b0, 32'd0, 100, 2);
    seen = 1'b0;
    foreach (pres_log[i]) if (pres_log[i] == 32'h200) seen = 1'b1;
    check_eq("no_jump_target", 32'(seen), 32'd0);
    if (pres_log.size() < 1) check_eq("int_pres_len", 32'd0, 32'd1);
    else check_eq("int_first", pres_log[0], 32'h80);

    // Slow memory with grant back-pressure.
    repeat (40) step(6'b0, 1'b0, 32'd0, 1'b0, 32'd0, 33, 3);

    // Fully random traffic, stalls and redirects.
    for (int i = 0; i < 300; i++) begin
      st = 6'($urandom & $urandom);
      r  = $urandom_range(99);
      step(st, (r < 4), 32'($urandom_range(4095)) << 2,
           (r >= 2 && r < 6), 32'($urandom_range(4095)) << 2, 60, 3);
    end

    // Reset with a response still pending.
    for (int i = 0; i < 20 && m_flight.size() == 0; i++)
      step(6'b0, 1'b0, 32'd0, 1'b0, 32'd0, 100, 3);
    check_eq("inflight_before_reset", 32'(m_flight.size() > 0), 32'd1);
    do_reset(1'b1);
    repeat (10) step(6'b0, 1'b0, 32'd0, 1'b0, 32'd0, 100, 2);
    check_eq("post_rst_first_req", 32'(first_req), 32'd1);
    if (grant_log.size() < 1) check_eq("post_rst_grant_len", 32'd0, 32'd1);
    else check_eq("post_rst_addr", grant_log[0], RST_ADDR);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
